// File: rtl/jtframe_mister_upld.sv
// NVRAM upload server: turns HPS byte reads into core NVRAM read requests,
// stalls the HPS with hps_wait until data is back, and tracks whether the
// NVRAM has been written since the last complete save.
//
// state  | meaning
// IDLE   | no read in flight, waiting for an HPS read strobe
// WAIT   | nvram_rd asserted, waiting for nvram_ok or timer expiry
module jtframe_mister_upld #(
  parameter int          AW        = 13,
  parameter logic [7:0]  IDX_NVRAM = 8'h2,
  parameter logic [7:0]  TIMEOUT   = 8'd255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hps_upload,
  input  logic [7:0]    hps_index,
  input  logic          hps_rd,
  input  logic [26:0]   hps_addr,
  output logic [7:0]    hps_din,
  output logic          hps_wait,
  output logic          uploading,
  output logic [AW-1:0] nvram_addr,
  output logic          nvram_rd,
  input  logic          nvram_ok,
  input  logic [7:0]    nvram_dout,
  input  logic          nvram_we,
  output logic          dirty,
  output logic          timeout
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t     state;
  logic [7:0] timer;
  logic       last_up;
  logic       served;

  logic is_nvram, out_range, up_rise, up_fall;

  // Combinational decode of the session edges and the read address range
  always_comb begin
    is_nvram  = hps_index == IDX_NVRAM;
    out_range = |hps_addr[26:AW];
    up_rise   = hps_upload & ~last_up;
    up_fall   = ~hps_upload & last_up;
  end

  // Session tracking, dirty flag and the read-serving FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      timer      <= 8'd0;
      last_up    <= 1'b0;
      served     <= 1'b0;
      hps_din    <= 8'd0;
      hps_wait   <= 1'b0;
      uploading  <= 1'b0;
      nvram_addr <= '0;
      nvram_rd   <= 1'b0;
      dirty      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      last_up <= hps_upload;
      if (up_rise && is_nvram) begin
        uploading <= 1'b1;
        timeout   <= 1'b0;
        served    <= 1'b0;
      end
      if (up_fall) begin
        uploading <= 1'b0;
        // a save only counts if something was delivered without timeouts
        if (served && !timeout) dirty <= 1'b0;
      end
      // a write always wins over the end-of-save clear
      if (nvram_we) dirty <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (hps_rd && uploading && is_nvram) begin
            if (out_range) begin
              hps_din <= 8'hFF;
              served  <= 1'b1;
            end else begin
              nvram_addr <= hps_addr[AW-1:0];
              nvram_rd   <= 1'b1;
              hps_wait   <= 1'b1;
              timer      <= 8'd0;
              state      <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (timer != TIMEOUT) timer <= timer + 8'd1;
          if (!hps_upload) begin
            nvram_rd <= 1'b0;
            hps_wait <= 1'b0;
            state    <= ST_IDLE;
          end else if (nvram_ok) begin
            hps_din  <= nvram_dout;
            nvram_rd <= 1'b0;
            hps_wait <= 1'b0;
            served   <= 1'b1;
            state    <= ST_IDLE;
          end else if (timer == TIMEOUT) begin
            hps_din  <= 8'hFF;
            nvram_rd <= 1'b0;
            hps_wait <= 1'b0;
            timeout  <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_mister_upld.sv
// Testbench for jtframe_mister_upld: random reads against a byte-array NVRAM
// image, with dirty/served/timeout tracked as plain session-level flags.
module tb_jtframe_mister_upld;

  logic        clk = 0;
  logic        rst = 1;
  logic        hps_upload = 0;
  logic [7:0]  hps_index = 8'h2;
  logic        hps_rd = 0;
  logic [26:0] hps_addr = '0;
  logic [7:0]  hps_din;
  logic        hps_wait;
  logic        uploading;
  logic [12:0] nvram_addr;
  logic        nvram_rd;
  logic        nvram_ok = 0;
  logic [7:0]  nvram_dout = 0;
  logic        nvram_we = 0;
  logic        dirty;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:8191];
  logic [7:0] exp_din;
  logic       m_dirty, m_served, m_tmo, m_up;

  jtframe_mister_upld #(.AW(13), .IDX_NVRAM(8'h2), .TIMEOUT(8'd255)) dut (
    .clk(clk), .rst(rst), .hps_upload(hps_upload), .hps_index(hps_index),
    .hps_rd(hps_rd), .hps_addr(hps_addr), .hps_din(hps_din),
    .hps_wait(hps_wait), .uploading(uploading), .nvram_addr(nvram_addr),
    .nvram_rd(nvram_rd), .nvram_ok(nvram_ok), .nvram_dout(nvram_dout),
    .nvram_we(nvram_we), .dirty(dirty), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_din = 8'd0; m_dirty = 0; m_served = 0; m_tmo = 0; m_up = 0;
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] got;
    got = {hps_din, nvram_addr, hps_wait, uploading, nvram_rd, dirty, timeout};
    checks++;
    if (got !== 32'd0) begin
      errors++;
      $display("FAIL %s outputs got %h exp 00000000", tag, got);
    end
  endtask

  task automatic start_session(input logic [7:0] idx);
    hps_index = idx;
    hps_upload = 1;
    tick();
    if (idx == 8'h2) begin
      m_up = 1; m_tmo = 0; m_served = 0;
    end
    checks++;
    if (uploading !== m_up || timeout !== m_tmo) begin
      errors++;
      $display("FAIL session_start up/tmo got %b%b exp %b%b", uploading, timeout, m_up, m_tmo);
    end
  endtask

  task automatic end_session(input logic we);
    hps_upload = 0;
    nvram_we = we;
    tick();
    nvram_we = 0;
    m_up = 0;
    if (we) m_dirty = 1;
    else if (m_served && !m_tmo) m_dirty = 0;
    checks++;
    if (uploading !== 1'b0 || dirty !== m_dirty) begin
      errors++;
      $display("FAIL session_end up/dirty got %b%b exp 0%b", uploading, dirty, m_dirty);
    end
  endtask

  task automatic pulse_we();
    nvram_we = 1;
    tick();
    nvram_we = 0;
    m_dirty = 1;
    checks++;
    if (dirty !== 1'b1) begin
      errors++;
      $display("FAIL we_pulse dirty got %b exp 1", dirty);
    end
  endtask

  // One HPS read; delay = cycles after nvram_rd rises before the core acks
  // (anything outside 0..255 means the core never acks). poke issues a
  // stray hps_rd while the request is pending.
  task automatic do_read(input logic [26:0] addr, input int delay, input bit poke, input string tag);
    int cyc;
    int exp_cyc;
    logic [7:0] exp_d;
    hps_rd = 1;
    hps_addr = addr;
    tick();
    hps_rd = 0;
    if (addr >= 27'd8192) begin
      exp_din = 8'hFF;
      m_served = 1;
      checks++;
      if (hps_wait !== 1'b0 || nvram_rd !== 1'b0 || hps_din !== exp_din) begin
        errors++;
        $display("FAIL %s oor wait/rd/din got %b %b %h exp 0 0 ff", tag, hps_wait, nvram_rd, hps_din);
      end
      tick();
      checks++;
      if (hps_wait !== 1'b0 || nvram_rd !== 1'b0) begin
        errors++;
        $display("FAIL %s oor_late wait/rd got %b %b exp 0 0", tag, hps_wait, nvram_rd);
      end
      return;
    end
    checks++;
    if (nvram_rd !== 1'b1 || hps_wait !== 1'b1 || nvram_addr !== addr[12:0]) begin
      errors++;
      $display("FAIL %s req rd/wait/addr got %b %b %h exp 1 1 %h", tag, nvram_rd, hps_wait, nvram_addr, addr[12:0]);
    end
    cyc = 0;
    while (hps_wait === 1'b1 && cyc < 400) begin
      hps_rd = (poke && cyc == 0);
      if (poke && cyc == 0) hps_addr = addr ^ 27'h5;
      if (cyc == delay) begin
        nvram_ok = 1;
        nvram_dout = mem[addr[12:0]];
      end else begin
        nvram_ok = 0;
        nvram_dout = 8'($urandom);
      end
      tick();
      cyc++;
    end
    hps_rd = 0;
    nvram_ok = 0;
    if (delay >= 0 && delay <= 255) begin
      exp_cyc = delay + 1;
      exp_d = mem[addr[12:0]];
      m_served = 1;
    end else begin
      exp_cyc = 256;
      exp_d = 8'hFF;
      m_tmo = 1;
    end
    exp_din = exp_d;
    checks++;
    if (cyc != exp_cyc) begin
      errors++;
      $display("FAIL %s wait_len got %0d exp %0d", tag, cyc, exp_cyc);
    end
    checks++;
    if (hps_din !== exp_d || nvram_rd !== 1'b0 || timeout !== m_tmo || nvram_addr !== addr[12:0]) begin
      errors++;
      $display("FAIL %s result din/rd/tmo/addr got %h %b %b %h exp %h 0 %b %h",
               tag, hps_din, nvram_rd, timeout, nvram_addr, exp_d, m_tmo, addr[12:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 0;
    tick();
    model_reset();
    check_all_zero("after_reset");
  endtask

  task automatic test_basic();
    start_session(8'h2);
    mem[13'h0010] = 8'h5A;
    do_read(27'h0010, 2, 0, "read_0x10");
    for (int i = 0; i < 10; i++)
      do_read(27'($urandom_range(8191, 0)), int'($urandom_range(6, 0)), bit'($urandom_range(1, 0)), "rand_read");
    do_read(27'h1FFF, 0, 0, "top_addr");
    do_read(27'h0123, 255, 0, "ack_at_limit");
    end_session(0);
  endtask

  task automatic test_out_of_range();
    start_session(8'h2);
    mem[13'h0042] = 8'h33;
    do_read(27'h0042, 1, 0, "pre_oor");
    do_read(27'h2000, 0, 0, "oor_0x2000");
    do_read(27'($urandom_range(32'h7FFFFFF, 32'h2000)), 0, 0, "oor_rand");
    end_session(0);
  endtask

  task automatic test_timeout();
    pulse_we();
    start_session(8'h2);
    do_read(27'($urandom_range(8191, 0)), 1, 0, "pre_tmo");
    do_read(27'($urandom_range(8191, 0)), 1000, 0, "no_ack");
    end_session(0);
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sticky got %b exp 1", timeout);
    end
  endtask

  task automatic test_dirty();
    pulse_we();
    start_session(8'h2);
    for (int i = 0; i < 4; i++) begin
      do_read(27'(i * 3), int'($urandom_range(4, 0)), 0, "dirty_read");
      checks++;
      if (dirty !== 1'b1) begin
        errors++;
        $display("FAIL dirty_during got %b exp 1", dirty);
      end
    end
    end_session(0);
    start_session(8'h2);
    do_read(27'h0007, 1, 0, "we_fall_read");
    end_session(1);
    start_session(8'h2);
    end_session(0);
  endtask

  task automatic test_abort();
    start_session(8'h2);
    do_read(27'h0055, 0, 0, "pre_abort");
    end_session(0);
    pulse_we();
    start_session(8'h2);
    hps_rd = 1;
    hps_addr = 27'h0100;
    tick();
    hps_rd = 0;
    repeat (2) tick();
    hps_upload = 0;
    tick();
    m_up = 0;
    checks++;
    if (nvram_rd !== 1'b0 || hps_wait !== 1'b0 || uploading !== 1'b0 || hps_din !== exp_din) begin
      errors++;
      $display("FAIL abort rd/wait/up/din got %b %b %b %h exp 0 0 0 %h", nvram_rd, hps_wait, uploading, hps_din, exp_din);
    end
    nvram_ok = 1;
    nvram_dout = ~exp_din;
    tick();
    nvram_ok = 0;
    tick();
    checks++;
    if (hps_din !== exp_din || hps_wait !== 1'b0 || nvram_rd !== 1'b0 || dirty !== m_dirty) begin
      errors++;
      $display("FAIL late_ok din/wait/rd/dirty got %h %b %b %b exp %h 0 0 %b", hps_din, hps_wait, nvram_rd, dirty, exp_din, m_dirty);
    end
  endtask

  task automatic test_ignored();
    hps_index = 8'h2;
    hps_rd = 1;
    hps_addr = 27'h0005;
    tick();
    hps_rd = 0;
    checks++;
    if (nvram_rd !== 1'b0 || hps_wait !== 1'b0 || hps_din !== exp_din) begin
      errors++;
      $display("FAIL no_session rd/wait/din got %b %b %h exp 0 0 %h", nvram_rd, hps_wait, hps_din, exp_din);
    end
    start_session(8'h0);
    hps_rd = 1;
    tick();
    hps_rd = 0;
    checks++;
    if (nvram_rd !== 1'b0 || hps_wait !== 1'b0 || hps_din !== exp_din) begin
      errors++;
      $display("FAIL idx0_session rd/wait/din got %b %b %h exp 0 0 %h", nvram_rd, hps_wait, hps_din, exp_din);
    end
    end_session(0);
    start_session(8'h2);
    hps_index = 8'h0;
    hps_rd = 1;
    tick();
    hps_rd = 0;
    checks++;
    if (nvram_rd !== 1'b0 || hps_wait !== 1'b0 || hps_din !== exp_din) begin
      errors++;
      $display("FAIL idx0_read rd/wait/din got %b %b %h exp 0 0 %h", nvram_rd, hps_wait, hps_din, exp_din);
    end
    hps_index = 8'h2;
    end_session(0);
  endtask

  task automatic test_async_reset();
    pulse_we();
    start_session(8'h2);
    hps_rd = 1;
    hps_addr = 27'h0abc;
    tick();
    hps_rd = 0;
    tick();
    checks++;
    if (nvram_rd !== 1'b1 || hps_wait !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst rd/wait got %b %b exp 1 1", nvram_rd, hps_wait);
    end
    #2;
    rst = 1;
    #1;
    check_all_zero("async_rst");
    hps_upload = 0;
    tick();
    rst = 0;
    model_reset();
    tick();
    check_all_zero("post_rst");
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    model_reset();
    test_reset();
    test_basic();
    test_out_of_range();
    test_timeout();
    test_dirty();
    test_abort();
    test_ignored();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
